// File: rtl/instr_encode_loader.sv
// Program-load engine: re-encodes decoded RV32I fields into instruction words,
// buffers them in a small FIFO and streams them to consecutive IMEM addresses.
module instr_encode_loader #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_f3,
    input  logic [6:0]        in_f7,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err_unknown,
    output logic [ADDR_W:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W+1:0] CAP = (ADDR_W+2)'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nx;
    logic [31:0]       mem [DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr, occ;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic              err;
    logic              fifo_empty, fifo_full, room, push, pop, open_sess;
    logic [32:0]       enc;

    // Returns {unsupported, word}; unsupported opcodes become a NOP.
    function automatic logic [32:0] encode(
        input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
        input logic [31:0] imm);
        logic [31:0] w;
        logic        unk;
        w   = 32'h0000_0013;
        unk = 1'b0;
        case (op)
            OP_R:     w = {f7, rs2, rs1, f3, rd, op};
            OP_IMM:   w = (f3 == 3'b001 || f3 == 3'b101) ? {f7, imm[4:0], rs1, f3, rd, op}
                                                         : {imm[11:0], rs1, f3, rd, op};
            OP_LOAD:  w = {imm[11:0], rs1, f3, rd, op};
            OP_S:     w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            OP_B:     w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            OP_LUI,
            OP_AUIPC: w = {imm[31:12], rd, op};
            default:  unk = 1'b1;
        endcase
        return {unk, w};
    endfunction

    assign enc        = encode(in_opcode, in_rd, in_rs1, in_rs2, in_f3, in_f7, in_imm);
    assign occ        = wr_ptr - rd_ptr;
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == (PW+1)'(DEPTH));
    // Words already written plus words in flight must stay below capacity.
    assign room       = ({1'b0, cnt} + (ADDR_W+2)'(occ)) < CAP;

    assign busy        = (state == S_LOAD) || (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign in_ready    = (state == S_LOAD) && !fifo_full && room;
    assign imem_we     = busy && !fifo_empty;
    assign imem_addr   = addr;
    assign imem_wdata  = imem_we ? mem[rd_ptr[PW-1:0]] : 32'h0;
    assign err_unknown = err;
    assign count       = cnt;
    assign push        = in_valid && in_ready;
    assign pop         = imem_we && imem_ready;
    assign open_sess   = start && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE,
            S_DONE:  if (start) state_nx = S_LOAD;
            S_LOAD:  if (finish) state_nx = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr   <= BASE;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
                if (enc[32]) err <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
                addr   <= addr + ADDR_W'(1);
                cnt    <= cnt + (ADDR_W+1)'(1);
            end
            if (open_sess) begin
                addr <= BASE;
                cnt  <= '0;
                err  <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= enc[31:0];
    end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: table vectors, directed corner sequences and a
// randomized run checked cycle-by-cycle against a queue-based reference model.
module tb_instr_encode_loader;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, finish = 1'b0;
    logic              in_valid = 1'b0, imem_ready = 1'b0;
    logic              in_ready, imem_we, busy, done, err_unknown;
    logic [6:0]        in_opcode = '0, in_f7 = '0;
    logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]        in_f3 = '0;
    logic [31:0]       in_imm = '0, imem_wdata;
    logic [ADDR_W-1:0] imem_addr;
    logic [ADDR_W:0]   count;

    instr_encode_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_f3(in_f3),
        .in_f7(in_f7), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .busy(busy), .done(done),
        .err_unknown(err_unknown), .count(count));

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [6:0] f7;
        logic [31:0] imm; logic [31:0] word;
    } vec_t;

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] exp_q[$];
    int          wr_idx = 0, phase = 0;  // phase: 0 idle, 1 load, 2 drain, 3 done
    logic        m_err = 1'b0, fire = 1'b0, acc = 1'b0;
    logic [31:0] fire_data;
    logic [ADDR_W-1:0] fire_addr;
    logic [6:0]  ops [0:7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoding built from field positions with shifts and masks.
    function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] b, w;
        b = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (op)
            7'h33: w = b | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
            7'h13: w = (f3 == 1 || f3 == 5)
                     ? b | (32'(rd) << 7) | (32'(f7) << 25) | ((imm & 32'h1F) << 20)
                     : b | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
            7'h03: w = b | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
            7'h23: w = b | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            7'h63: w = b | (32'(rs2) << 20) | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                         | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
            7'h37, 7'h17: w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
            default: return {1'b1, 32'h0000_0013};
        endcase
        return {1'b0, w};
    endfunction

    // Sample at the falling edge, check against model, advance model, then step.
    task automatic cyc();
        logic exp_busy, exp_rdy, empty0;
        logic [32:0] r;
        @(negedge clk);
        fire = 1'b0; acc = 1'b0;
        if (!rst_n) begin
            chk("rst_we", imem_we, 0);       chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);        chk("rst_in_ready", in_ready, 0);
            chk("rst_count", count, 0);      chk("rst_err", err_unknown, 0);
            chk("rst_addr", imem_addr, 0);   chk("rst_wdata", imem_wdata, 0);
            exp_q.delete(); wr_idx = 0; phase = 0; m_err = 1'b0;
        end else begin
            exp_busy = (phase == 1 || phase == 2);
            exp_rdy  = (phase == 1) && (exp_q.size() < DEPTH) && (wr_idx + exp_q.size() < CAP);
            chk("busy", busy, exp_busy);
            chk("done", done, phase == 3);
            chk("err_unknown", err_unknown, m_err);
            chk("count", count, wr_idx);
            chk("imem_we", imem_we, exp_busy && exp_q.size() > 0);
            chk("in_ready", in_ready, exp_rdy);
            empty0 = (exp_q.size() == 0);
            if (exp_busy && !empty0 && imem_ready) begin
                fire = 1'b1; fire_data = imem_wdata; fire_addr = imem_addr;
                chk("wdata", imem_wdata, exp_q[0]);
                chk("addr", imem_addr, wr_idx);
                void'(exp_q.pop_front());
                wr_idx++;
            end
            if (in_valid && exp_rdy) begin
                acc = 1'b1;
                r = ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_f3, in_f7, in_imm);
                exp_q.push_back(r[31:0]);
                if (r[32]) m_err = 1'b1;
            end
            case (phase)
                0, 3: if (start) begin phase = 1; exp_q.delete(); wr_idx = 0; m_err = 1'b0; end
                1: if (finish) phase = 2;
                2: if (empty0) phase = 3;
                default: ;
            endcase
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_beat();
        int k;
        k = $urandom_range(0, 9);
        in_opcode = (k < 8) ? ops[k] : 7'($urandom);
        in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
        in_f3 = 3'($urandom); in_f7 = 7'($urandom); in_imm = $urandom;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1; cyc(); finish = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 200 && !done; k++) cyc();
        chk(nm, done, 1);
    endtask

    vec_t tv [9];
    int   accepted, lat;
    logic [31:0] hold_data;
    logic [ADDR_W-1:0] hold_addr;

    initial begin
        tv[0] = '{7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0,         32'h002081B3};
        tv[1] = '{7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         32'h00500093};
        tv[2] = '{7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         32'h0020A423};
        tv[3] = '{7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFD, 32'hFE208EE3};
        tv[4] = '{7'h37, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h123452B7};
        tv[5] = '{7'h13, 5'd1,  5'd1, 5'd0, 3'd5, 7'h20, 32'd3,         32'h4030D093};
        tv[6] = '{7'h03, 5'd5,  5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFF_FFF8, 32'hFF812283};
        tv[7] = '{7'h17, 5'd7,  5'd0, 5'd0, 3'd0, 7'h00, 32'hABCD_E123, 32'hABCDE397};
        tv[8] = '{7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd8,         32'h00000013};

        repeat (3) cyc();
        rst_n = 1'b1; imem_ready = 1'b1;
        cyc();

        // Table vectors, one beat at a time, checking word, address and latency.
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            in_opcode = tv[i].op; in_rd = tv[i].rd; in_rs1 = tv[i].rs1; in_rs2 = tv[i].rs2;
            in_f3 = tv[i].f3; in_f7 = tv[i].f7; in_imm = tv[i].imm; in_valid = 1'b1;
            for (int k = 0; k < 20; k++) begin cyc(); if (acc) break; end
            in_valid = 1'b0;
            fire_data = 'x; lat = 0;
            for (int k = 0; k < 20; k++) begin cyc(); lat++; if (fire) break; end
            chk($sformatf("tv%0d_word", i), fire_data, tv[i].word);
            chk($sformatf("tv%0d_addr", i), fire_addr, i);
            chk($sformatf("tv%0d_latency", i), lat, 1);
        end
        chk("err_after_unknown", err_unknown, 1);
        pulse_finish();
        wait_done("tv_done");
        chk("tv_count", count, 9);
        pulse_finish();
        chk("finish_ignored_in_done", done, 1);

        // Stalled IMEM: FIFO fills at DEPTH, write port holds steady.
        pulse_start();
        chk("err_cleared", err_unknown, 0);
        chk("count_cleared", count, 0);
        imem_ready = 1'b0; accepted = 0;
        rand_beat(); in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin cyc(); if (acc) begin accepted++; rand_beat(); end end
        chk("stall_accepted", accepted, DEPTH);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_we", imem_we, 1);
        hold_data = imem_wdata; hold_addr = imem_addr;
        repeat (3) cyc();
        chk("stall_wdata_stable", imem_wdata, hold_data);
        chk("stall_addr_stable", imem_addr, hold_addr);
        imem_ready = 1'b1;
        for (int k = 0; k < 40 && accepted < 6; k++) begin
            cyc();
            if (acc) begin accepted++; if (accepted < 6) rand_beat(); end
        end
        in_valid = 1'b0;
        pulse_finish();
        wait_done("stall_done");
        chk("stall_count", count, 6);

        // finish together with the last beat keeps the beat.
        pulse_start();
        rand_beat(); in_valid = 1'b1; finish = 1'b1;
        cyc();
        in_valid = 1'b0; finish = 1'b0;
        chk("fin_with_beat_acc", acc, 1);
        wait_done("fin_done");
        chk("fin_count", count, 1);

        // Capacity: accept stops at 2**ADDR_W words; a start mid-LOAD is ignored.
        pulse_start();
        accepted = 0; rand_beat(); in_valid = 1'b1;
        for (int k = 0; k < CAP + 12; k++) begin
            start = (k == 10);
            cyc();
            if (acc) begin accepted++; rand_beat(); end
        end
        start = 1'b0; in_valid = 1'b0;
        chk("cap_accepted", accepted, CAP);
        chk("cap_in_ready", in_ready, 0);
        chk("cap_count", count, CAP);
        pulse_finish();
        wait_done("cap_done");

        // Randomized traffic with random start/finish pulses and IMEM stalls.
        for (int k = 0; k < 1500; k++) begin
            rand_beat();
            in_valid   = ($urandom_range(0, 2) != 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 60) == 0);
            finish     = ($urandom_range(0, 50) == 0);
            cyc();
        end
        in_valid = 1'b0; start = 1'b0; imem_ready = 1'b1;
        pulse_finish();
        for (int k = 0; k < 50 && (busy || phase == 1 || phase == 2); k++) cyc();
        chk("rand_model_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a stalled write.
        pulse_start();
        imem_ready = 1'b0; rand_beat(); in_valid = 1'b1;
        repeat (2) cyc();
        in_valid = 1'b0;
        chk("pre_reset_we", imem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_we", imem_we, 0);
        cyc();
        rst_n = 1'b1; imem_ready = 1'b1;
        cyc();
        pulse_finish();
        chk("idle_after_reset", busy, 0);
        chk("finish_ignored_in_idle", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
